// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth recoding table for the sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Selected multiple = (sel ? (dbl ? 2b : b) : 0), negated when neg is set.
    typedef struct packed {
        logic sel;
        logic dbl;
        logic neg;
    } booth_digit_t;

    localparam logic [2:0] TRIP_ZERO_LO = 3'b000;
    localparam logic [2:0] TRIP_P1_A    = 3'b001;
    localparam logic [2:0] TRIP_P1_B    = 3'b010;
    localparam logic [2:0] TRIP_P2      = 3'b011;
    localparam logic [2:0] TRIP_M2      = 3'b100;
    localparam logic [2:0] TRIP_M1_A    = 3'b101;
    localparam logic [2:0] TRIP_M1_B    = 3'b110;
    localparam logic [2:0] TRIP_ZERO_HI = 3'b111;

    function automatic booth_digit_t booth_r4_decode(input logic [2:0] triplet);
        booth_digit_t d;
        d = '0;
        case (triplet)
            TRIP_P1_A, TRIP_P1_B: d.sel = 1'b1;
            TRIP_P2:              begin d.sel = 1'b1; d.dbl = 1'b1; end
            TRIP_M2:              begin d.sel = 1'b1; d.dbl = 1'b1; d.neg = 1'b1; end
            TRIP_M1_A, TRIP_M1_B: begin d.sel = 1'b1; d.neg = 1'b1; end
            default:              d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// One radix-4 Booth digit: picks 0/+-b_x/+-2b_x; negatives leave as one's complement plus carry-in.
module booth_r4_digit
    import booth_pkg::*;
#(
    parameter int XW = 10
) (
    input  logic [2:0]    i_triplet,
    input  logic [XW-1:0] i_b_x,
    output logic [XW-1:0] o_mult,
    output logic          o_cin
);

    booth_digit_t  w_dig;
    logic [XW-1:0] w_mag;
    logic [XW-1:0] w_sel;

    // b_x carries two guard bits, so doubling it cannot overflow XW.
    always_comb begin
        w_dig  = booth_r4_decode(i_triplet);
        w_mag  = w_dig.dbl ? {i_b_x[XW-2:0], 1'b0} : i_b_x;
        w_sel  = w_dig.sel ? w_mag : '0;
        o_mult = w_dig.neg ? ~w_sel : w_sel;
        o_cin  = w_dig.neg;
    end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier retiring one digit per clock through a single shared adder.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never depends on ready.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int XW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 2;
    localparam int CW = $clog2(WIDTH / 2 + 2);
    localparam logic [CW-1:0] LAST_S = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] LAST_U = CW'(WIDTH / 2);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [XW:0]          r_a_sh;
    logic [XW-1:0]        r_b_x;
    logic                 r_signed;
    logic [AW-1:0]        r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [XW-1:0]        w_a_x;
    logic [XW-1:0]        w_b_x;
    logic                 w_last;
    logic [XW-1:0]        w_mult;
    logic                 w_cin;
    logic [AW-1:0]        w_mult_ext;
    logic [CW:0]          w_shamt;
    logic [AW-1:0]        w_addend;
    logic [AW-1:0]        w_acc_nxt;

    assign w_a_x  = {{2{is_signed & a[WIDTH-1]}}, a};
    assign w_b_x  = {{2{is_signed & b[WIDTH-1]}}, b};
    assign w_last = (r_cnt == (r_signed ? LAST_S : LAST_U));

    booth_r4_digit #(.XW(XW)) u_digit (
        .i_triplet (r_a_sh[2:0]),
        .i_b_x     (r_b_x),
        .o_mult    (w_mult),
        .o_cin     (w_cin)
    );

    // Filling the vacated low bits with ones keeps the shifted one's complement exact,
    // so a single carry-in at bit 0 completes the negation.
    assign w_mult_ext = {{(AW-XW){w_mult[XW-1]}}, w_mult};
    assign w_shamt    = {r_cnt, 1'b0};
    assign w_addend   = (w_mult_ext << w_shamt) | (w_cin ? ~({AW{1'b1}} << w_shamt) : '0);
    assign w_acc_nxt  = r_acc + w_addend + AW'(w_cin);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_x     <= '0;
            r_signed  <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_a_sh   <= {w_a_x, 1'b0};
            r_b_x    <= w_b_x;
            r_signed <= is_signed;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_acc  <= w_acc_nxt;
            r_a_sh <= r_a_sh >> 2;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) r_product <= w_acc_nxt[2*WIDTH-1:0];
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign product   = r_product;

endmodule
